dct_transpose_buf: RTL

DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

---
 rtl/dct_pkg.sv | 14 +
 rtl/dct_tbuf_bank.sv | 33 +++
 rtl/dct_transpose_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared parameters and lane type for the 2-D DCT datapath.
package dct_pkg;

    localparam int DCT_SIZE = 12;
    localparam int DCT_N    = 8;

    typedef logic signed [DCT_SIZE-1:0] coef_t;

    // Width of a row/column index for an n x n block (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One N x N coefficient bank: whole-row write, whole-column combinational read.
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int SIZE = DCT_SIZE,
    parameter int N    = DCT_N,
    localparam int IW  = idx_w(N)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     wr_row,
    input  logic [N*SIZE-1:0] row_data,
    input  logic [IW-1:0]     rd_col,
    output logic [N*SIZE-1:0] col_data
);

    logic [N*SIZE-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row] <= row_data;
        end
    end

    // Column lane k is lane rd_col of stored row k.
    always_comb begin
        col_data = '0;
        for (int k = 0; k < N; k++) begin
            col_data[k*SIZE +: SIZE] = mem[k][int'(rd_col)*SIZE +: SIZE];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the row and column DCT passes:
// rows go in, columns come out, one block per bank.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int SIZE = DCT_SIZE,
    parameter int N    = DCT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*SIZE-1:0] in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*SIZE-1:0] out_col,
    output logic              out_last
);

    localparam int IW = idx_w(N);

    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] rd_col;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_last;
    logic          rd_last;
    logic [1:0]    we;
    logic [N*SIZE-1:0] col0;
    logic [N*SIZE-1:0] col1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // ready and valid depend only on registered state, never on the peer.
    assign in_ready  = !full[wr_bank];
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = (wr_row == IW'(N-1));
    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && out_ready;
    assign rd_last   = (rd_col == IW'(N-1));
    assign out_last  = out_valid && rd_last;

    assign we[0] = wr_fire && !wr_bank;
    assign we[1] = wr_fire &&  wr_bank;

    dct_tbuf_bank #(.SIZE(SIZE), .N(N)) u_bank0 (
        .clk      (clk),
        .we       (we[0]),
        .wr_row   (wr_row),
        .row_data (in_row),
        .rd_col   (rd_col),
        .col_data (col0)
    );

    dct_tbuf_bank #(.SIZE(SIZE), .N(N)) u_bank1 (
        .clk      (clk),
        .we       (we[1]),
        .wr_row   (wr_row),
        .row_data (in_row),
        .rd_col   (rd_col),
        .col_data (col1)
    );

    always_comb begin
        out_col = '0;
        if (out_valid) begin
            out_col = rd_bank ? col1 : col0;
        end
    end

    // A set and a clear can land together; they always target different
    // banks because one needs the bank empty and the other needs it full.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_row  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_row <= wr_row + IW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rd_col  <= '0;
                    rd_bank <= !rd_bank;
                end else begin
                    rd_col <= rd_col + IW'(1);
                end
            end
        end
    end

endmodule
